// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch sequencer.
// FSM state encodings and default memory geometry.
package if_fetch_ctrl_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_STALL = 3'd4,
        ST_FLUSH = 3'd5,
        ST_HALT  = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_im_loader.sv
// Instruction-memory boot loader: ld handshake, write address counter,
// sticky overflow flag and optional running checksum (LOAD_CHECKSUM_EN).
module if_fetch_ctrl_im_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              ready_nxt,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_data,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_ovf,
    output logic [DATA_W-1:0] ld_checksum
);

    logic accept;

    assign accept = ld_valid & ld_ready;

    // Accepted word becomes an IM write one cycle later; count past depth wraps the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_data  <= '0;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
        end else begin
            ld_ready <= ready_nxt;
            im_we    <= accept;
            if (clear) begin
                ld_count <= '0;
                ld_ovf   <= 1'b0;
            end else if (accept) begin
                im_addr  <= ld_count[ADDR_W-1:0];
                im_data  <= ld_data;
                ld_count <= ld_count + 1'b1;
                ld_ovf   <= ld_ovf | ld_count[ADDR_W];
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    // Modular sum of accepted words, updated alongside the IM write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_checksum <= '0;
        end else if (clear) begin
            ld_checksum <= '0;
        end else if (accept) begin
            ld_checksum <= ld_checksum + ld_data;
        end
    end
`else
    assign ld_checksum = '0;
`endif

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: boots IM via loader, then drives PC reset/write and fetch-valid.
// Optional checksum of loaded words when LOAD_CHECKSUM_EN is defined.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BRANCH_BUBBLES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              start,
    input  logic              stall,
    input  logic              tf_out,
    input  logic              halt,
    output logic              im_WE,
    output logic [ADDR_W-1:0] im_ADDR,
    output logic [DATA_W-1:0] im_DATA,
    output logic              pc_RESET,
    output logic              uc_W_PC,
    output logic              if_valid,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_ovf,
    output logic [DATA_W-1:0] ld_checksum
);

    localparam logic [1:0] FLUSH_INIT = 2'(BRANCH_BUBBLES - 1);

    fetch_state_e state_q, state_d;
    logic [1:0]   flush_q, flush_d;
    logic         clear;
    logic         accept;
    logic         pc_reset_d, w_pc_d, valid_d;

    assign accept = ld_valid & ld_ready;

    if_fetch_ctrl_im_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk         (CLK),
        .rst         (RESET),
        .clear       (clear),
        .ready_nxt   (state_d == ST_LOAD),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .im_we       (im_WE),
        .im_addr     (im_ADDR),
        .im_data     (im_DATA),
        .ld_count    (ld_count),
        .ld_ovf      (ld_ovf),
        .ld_checksum (ld_checksum)
    );

    // State, flush counter and registered PC controls.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            flush_q  <= '0;
            pc_RESET <= 1'b1;
            uc_W_PC  <= 1'b0;
            if_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            pc_RESET <= pc_reset_d;
            uc_W_PC  <= w_pc_d;
            if_valid <= valid_d;
        end
    end

    // Next state (halt > tf_out > stall) and next-cycle PC controls.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end else if (start && ld_count != '0) begin
                    state_d = ST_PRIME;
                end
            end
            ST_LOAD: begin
                if (accept && ld_last) state_d = ST_IDLE;
            end
            ST_PRIME: state_d = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (tf_out) begin
                    state_d = ST_FLUSH;
                    flush_d = FLUSH_INIT;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (flush_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_d = flush_q - 1'b1;
                end
            end
            ST_HALT: begin
                if (ld_valid) begin
                    state_d = ST_LOAD;
                    clear   = 1'b1;
                end else if (start) begin
                    state_d = ST_PRIME;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pc_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOAD)
                  || (state_d == ST_PRIME && state_q == ST_HALT);
        w_pc_d     = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        valid_d    = (state_d == ST_RUN)
                  || (state_d == ST_STALL && if_valid);
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: vector table through a scoreboard queue,
// plus mid-load reset and small-memory overflow sequences.
module tb_if_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;

    logic        ld_valid = 0, ld_last = 0, start = 0, stall = 0, tf_out = 0, halt = 0;
    logic [31:0] ld_data = '0;
    logic        ld_ready, im_WE, pc_RESET, uc_W_PC, if_valid, ld_ovf;
    logic [7:0]  im_ADDR;
    logic [31:0] im_DATA, ld_checksum;
    logic [8:0]  ld_count;

    logic        lv2 = 0, ll2 = 0, st2 = 0, sl2 = 0, tf2 = 0, hl2 = 0;
    logic [31:0] ld2 = '0;
    logic        rdy2, we2, pcr2, wpc2, v2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] data2, cks2;
    logic [2:0]  cnt2;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    if_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .BRANCH_BUBBLES(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .start(start), .stall(stall), .tf_out(tf_out), .halt(halt),
        .im_WE(im_WE), .im_ADDR(im_ADDR), .im_DATA(im_DATA),
        .pc_RESET(pc_RESET), .uc_W_PC(uc_W_PC), .if_valid(if_valid),
        .ld_count(ld_count), .ld_ovf(ld_ovf), .ld_checksum(ld_checksum)
    );

    if_fetch_ctrl #(.ADDR_W(2), .DATA_W(32), .BRANCH_BUBBLES(1)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .ld_valid(lv2), .ld_data(ld2), .ld_last(ll2), .ld_ready(rdy2),
        .start(st2), .stall(sl2), .tf_out(tf2), .halt(hl2),
        .im_WE(we2), .im_ADDR(addr2), .im_DATA(data2),
        .pc_RESET(pcr2), .uc_W_PC(wpc2), .if_valid(v2),
        .ld_count(cnt2), .ld_ovf(ovf2), .ld_checksum(cks2)
    );

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        ll, st, sl, tf, hl;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        pcr, wpc, vld, rdy;
        logic [8:0]  cnt;
    } vec_t;

    vec_t vt[27];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic lv, input logic [31:0] ld, input logic ll, input logic st,
        input logic sl, input logic tf, input logic hl, input logic we,
        input logic [7:0] addr, input logic [31:0] data, input logic pcr,
        input logic wpc, input logic vld, input logic rdy, input logic [8:0] cnt);
        vec_t r;
        r.lv = lv; r.ld = ld; r.ll = ll; r.st = st; r.sl = sl; r.tf = tf; r.hl = hl;
        r.we = we; r.addr = addr; r.data = data;
        r.pcr = pcr; r.wpc = wpc; r.vld = vld; r.rdy = rdy; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] W0 = 32'h2000_0000;
    localparam logic [31:0] W1 = 32'h1100_0000;
    localparam logic [31:0] W2 = 32'hFFFF_FFFF;
    localparam logic [31:0] W3 = 32'h0000_0005;

    initial begin
        vec_t e;
        logic [31:0] sum2;

        //       lv ld  ll st sl tf hl  we ad dat  pcr wpc v rdy cnt
        vt[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vt[1]  = mk(0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        vt[2]  = mk(1, W0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
        vt[3]  = mk(1, W0, 0, 0, 0, 0, 0, 1, 0, W0, 1, 0, 0, 1, 1);
        vt[4]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1);
        vt[5]  = mk(1, W1, 0, 0, 0, 0, 0, 1, 1, W1, 1, 0, 0, 1, 2);
        vt[6]  = mk(1, W2, 1, 1, 0, 0, 0, 1, 2, W2, 1, 0, 0, 0, 3);
        vt[7]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3);
        vt[8]  = mk(0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
        vt[9]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[10] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[11] = mk(0, 0,  0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 3);
        vt[12] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 3);
        vt[13] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[14] = mk(0, 0,  0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 3);
        vt[15] = mk(0, 0,  0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 3);
        vt[16] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[17] = mk(0, 0,  0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 3);
        vt[18] = mk(0, 0,  0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 3);
        vt[19] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[20] = mk(0, 0,  0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 3);
        vt[21] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
        vt[22] = mk(0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3);
        vt[23] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 3);
        vt[24] = mk(0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 3);
        vt[25] = mk(1, W3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
        vt[26] = mk(1, W3, 1, 0, 0, 0, 0, 1, 0, W3, 1, 0, 0, 0, 1);

        // asynchronous reset mid-cycle
        #2 RESET = 1'b1;
        #1;
        chk("rst_pc_RESET", 32'(pc_RESET), 32'd1);
        chk("rst_uc_W_PC", 32'(uc_W_PC), 32'd0);
        chk("rst_im_WE", 32'(im_WE), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        chk("rst_ld_ovf", 32'(ld_ovf), 32'd0);
        chk("rst_cksum", ld_checksum, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 27; i++) begin
            ld_valid = vt[i].lv; ld_data = vt[i].ld; ld_last = vt[i].ll;
            start = vt[i].st; stall = vt[i].sl; tf_out = vt[i].tf; halt = vt[i].hl;
            sb.push_back(vt[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_im_WE", i), 32'(im_WE), 32'(e.we));
            if (e.we) begin
                chk($sformatf("v%0d_im_ADDR", i), 32'(im_ADDR), 32'(e.addr));
                chk($sformatf("v%0d_im_DATA", i), im_DATA, e.data);
            end
            chk($sformatf("v%0d_pc_RESET", i), 32'(pc_RESET), 32'(e.pcr));
            chk($sformatf("v%0d_uc_W_PC", i), 32'(uc_W_PC), 32'(e.wpc));
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(e.vld));
            chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(e.rdy));
            chk($sformatf("v%0d_ld_count", i), 32'(ld_count), 32'(e.cnt));
            chk($sformatf("v%0d_ld_ovf", i), 32'(ld_ovf), 32'd0);
            if (i == 7) begin
`ifdef LOAD_CHECKSUM_EN
                chk("cksum3", ld_checksum, 32'h30FF_FFFF);
`else
                chk("cksum3", ld_checksum, 32'd0);
`endif
            end
            @(negedge CLK);
        end
        ld_valid = 0; ld_last = 0;

        // reset in the middle of a load discards the partial count
        ld_valid = 1; ld_data = 32'hA;
        step();
        @(negedge CLK);
        step();
        @(negedge CLK);
        step();
        chk("mid_ld_count", 32'(ld_count), 32'd2);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_count", 32'(ld_count), 32'd0);
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_pc", 32'(pc_RESET), 32'd1);
        chk("mid_rst_we", 32'(im_WE), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        ld_valid = 0; start = 1;
        step();
        chk("start_cnt0_pc", 32'(pc_RESET), 32'd1);
        chk("start_cnt0_wpc", 32'(uc_W_PC), 32'd0);
        @(negedge CLK);
        start = 0;

        // small memory: fifth word wraps to address 0 and flags overflow
        lv2 = 1; ld2 = 32'h1;
        step();
        chk("ovf_enter_rdy", 32'(rdy2), 32'd1);
        sum2 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            ld2 = 32'h8000_0000 + 32'(i);
            ll2 = (i == 4);
            sum2 = sum2 + ld2;
            step();
            chk($sformatf("ovf%0d_we", i), 32'(we2), 32'd1);
            chk($sformatf("ovf%0d_addr", i), 32'(addr2), 32'(i % 4));
            chk($sformatf("ovf%0d_flag", i), 32'(ovf2), 32'(i == 4));
            chk($sformatf("ovf%0d_cnt", i), 32'(cnt2), 32'(i + 1));
        end
`ifdef LOAD_CHECKSUM_EN
        chk("ovf_cksum", cks2, sum2);
`else
        chk("ovf_cksum", cks2, 32'd0);
`endif
        @(negedge CLK);
        lv2 = 0; ll2 = 0; st2 = 1;
        step();
        chk("ovf_prime_v", 32'(v2), 32'd0);
        chk("ovf_sticky1", 32'(ovf2), 32'd1);
        @(negedge CLK);
        st2 = 0;
        step();
        chk("ovf_run_v", 32'(v2), 32'd1);
        @(negedge CLK);
        tf2 = 1;
        step();
        chk("bb1_flush_v", 32'(v2), 32'd0);
        chk("bb1_flush_wpc", 32'(wpc2), 32'd1);
        @(negedge CLK);
        tf2 = 0;
        step();
        chk("bb1_run_v", 32'(v2), 32'd1);
        @(negedge CLK);
        hl2 = 1;
        step();
        chk("ovf_halt_wpc", 32'(wpc2), 32'd0);
        chk("ovf_sticky2", 32'(ovf2), 32'd1);
        @(negedge CLK);
        hl2 = 0; lv2 = 1;
        step();
        chk("reload_ovf_clr", 32'(ovf2), 32'd0);
        chk("reload_cnt_clr", 32'(cnt2), 32'd0);
        chk("reload_pc", 32'(pcr2), 32'd1);
        @(negedge CLK);
        lv2 = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
